tensor_core_mma_seq: RTL and testbench
======================================

# tensor_core_mma_seq

Sequencer that runs a full 4x4 by 4x4 matrix multiply on the single-element tensor-core MMA datapath. The datapath is a combinational A-row · B-column dot product plus C accumulate. The block stores the A rows and B columns loaded by the host. It schedules the 16 row/column pairs onto the datapath one per cycle, keeps the 16 results in an internal C buffer, optionally feeds them back as C_in for K-tile accumulation, and streams them out with a valid/ready handshake. It sits between the host load/result interface and one `tensor_core_mma` instance.

## Interface
- DWIDTH, 16, fp16 operand width
- AWIDTH, 91, accumulator / result width (matches MMA C_in/C_out)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_load_valid  in  1  load beat valid
- o_load_ready  out  1  load beat accepted; high only in IDLE
- i_load_sel  in  1  0 = A row, 1 = B column
- i_load_idx  in  2  row (A) or column (B) index
- i_load_data  in  4*DWIDTH  four elements, element 0 in bits [DWIDTH-1:0]
- i_start  in  1  start request, sampled only in IDLE
- i_acc  in  1  sampled with i_start; 1 = C_in from stored C, 0 = C_in zero
- o_busy  out  1  high in COMPUTE and DRAIN
- o_done  out  1  one-cycle pulse after last result transfer
- o_mma_a  out  4*DWIDTH  A row to datapath
- o_mma_b  out  4*DWIDTH  B column to datapath
- o_mma_c  out  AWIDTH  C_in to datapath
- i_mma_c  in  AWIDTH  C_out from datapath (combinational path, same cycle)
- o_res_valid  out  1  result valid
- i_res_ready  in  1  result accepted
- o_res_data  out  AWIDTH  result C[row][col]
- o_res_row  out  2  result row
- o_res_col  out  2  result column
- o_res_last  out  1  high with element 15

## Operation
- Storage: A[0..3] and B[0..3], each 4*DWIDTH; C[0..15], each AWIDTH; 4-bit element counter cnt; acc_mode flag. Everything resets to 0.
- Load: in IDLE, a beat with i_load_valid & o_load_ready writes i_load_data to A[idx] or B[idx]. Loads in other states are not accepted (ready low). Writing the same index again overwrites it.
- States: IDLE, COMPUTE, DRAIN.
- IDLE -> COMPUTE when i_start = 1. On that edge: cnt <= 0 and acc_mode <= i_acc. i_start outside IDLE is ignored.
- A load and i_start on the same edge are both taken. The compute uses the newly written data.
- COMPUTE, each cycle with row = cnt[3:2] and col = cnt[1:0]:
  - o_mma_a = A[row], o_mma_b = B[col], o_mma_c = acc_mode ? C[cnt] : 0.
  - On the edge: C[cnt] <= i_mma_c and cnt <= cnt+1.
  - After cnt = 15 is captured: -> DRAIN with cnt <= 0.
- Outside COMPUTE, o_mma_a/b/c are 0.
- DRAIN:
  - o_res_valid = 1.
  - o_res_data = C[cnt], o_res_row = cnt[3:2], o_res_col = cnt[1:0], o_res_last = (cnt == 15).
  - A transfer (valid & ready) increments cnt.
  - Transfer with o_res_last -> IDLE and o_done = 1 for the following cycle.
  - Outputs hold stable while i_res_ready is low.
- C is kept after DRAIN. The next start with i_acc = 1 accumulates onto it; i_acc = 0 overwrites it.
- Width rules: no truncation; i_mma_c is stored as full AWIDTH. Datapath exception flags are not consumed.
- Reset mid-operation: immediate return to IDLE. A, B and C are cleared. All outputs go to reset values, and no o_done is issued.

## Timing
- Reset values: o_load_ready 1, all other outputs 0.
- Edge E0 accepts start. Cycles E0..E15 present elements 0..15 to the datapath (one per cycle, row-major). E16 captures element 15 and enters DRAIN.
- First o_res_valid is in the cycle after E16. With i_res_ready held high, 16 consecutive transfers follow. o_done pulses in the cycle after the last transfer, which is also the first IDLE cycle (o_load_ready = 1 again).
- Minimum start-to-done latency: 33 cycles. The datapath combinational delay must fit one clock period.
- o_busy falls in the same cycle o_done rises.

## Test plan
- Datapath model used by the bench: C_out = C_in + 1.
- Load A rows = {16'h3C00 x4}, B columns = {16'h4000 x4}, start with i_acc = 0 -> during COMPUTE o_mma_a = 64'h3C003C003C003C00 and o_mma_b = 64'h4000400040004000. 16 results equal to 1 appear in row-major order; o_res_last is high only on (3,3); o_done pulses once at cycle 33.
- Back-to-back start with i_acc = 1 -> all 16 results equal 2. A third start with i_acc = 0 -> all results equal 1 again.
- Backpressure: i_res_ready toggles 1,0,0,1 repeatedly -> no result lost or duplicated, o_res_data stable while stalled, row/col sequence correct.
- Load beat with i_start on the same edge (A[2] = 16'h4400 x4) -> the compute cycles with row = 2 show the new A[2]. A load attempted during COMPUTE sees o_load_ready = 0 and leaves A unchanged.
- rst_n asserted at cnt = 7 of COMPUTE, and again mid-DRAIN -> state IDLE, all outputs at reset values, no o_done. A following i_acc = 1 run returns results equal to 1 (C cleared).
- i_start pulsed during COMPUTE and during DRAIN -> ignored, exactly one o_done per accepted start.

Source files
------------

// File: rtl/tensor_core_mma_seq.sv
// Sequences a 4x4 x 4x4 matrix multiply through one combinational MMA dot-product datapath.
// Latency: 16 compute cycles plus 16 drain beats (33 cycles start-to-done); i_res_ready low stalls the drain.
module tensor_core_mma_seq #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 91
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic                  i_load_sel,
    input  logic [1:0]            i_load_idx,
    input  logic [4*DWIDTH-1:0]   i_load_data,
    input  logic                  i_start,
    input  logic                  i_acc,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DWIDTH-1:0]   o_mma_a,
    output logic [4*DWIDTH-1:0]   o_mma_b,
    output logic [AWIDTH-1:0]     o_mma_c,
    input  logic [AWIDTH-1:0]     i_mma_c,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [AWIDTH-1:0]     o_res_data,
    output logic [1:0]            o_res_row,
    output logic [1:0]            o_res_col,
    output logic                  o_res_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [4*DWIDTH-1:0] a_q [4];
    logic [4*DWIDTH-1:0] a_d [4];
    logic [4*DWIDTH-1:0] b_q [4];
    logic [4*DWIDTH-1:0] b_d [4];
    logic [AWIDTH-1:0]   c_q [16];
    logic [AWIDTH-1:0]   c_d [16];
    logic [3:0]          cnt_q, cnt_d;
    logic                acc_mode_q, acc_mode_d;
    logic                done_q, done_d;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        cnt_d        = cnt_q;
        acc_mode_d   = acc_mode_q;
        done_d       = 1'b0;
        o_load_ready = 1'b0;
        o_busy       = 1'b0;
        o_mma_a      = '0;
        o_mma_b      = '0;
        o_mma_c      = '0;
        o_res_valid  = 1'b0;
        o_res_data   = '0;
        o_res_row    = 2'd0;
        o_res_col    = 2'd0;
        o_res_last   = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_load_ready = 1'b1;
                if (i_load_valid) begin
                    if (i_load_sel) b_d[i_load_idx] = i_load_data;
                    else            a_d[i_load_idx] = i_load_data;
                end
                if (i_start) begin
                    state_d    = S_COMPUTE;
                    cnt_d      = 4'd0;
                    acc_mode_d = i_acc;
                end
            end
            S_COMPUTE: begin
                o_busy       = 1'b1;
                o_mma_a      = a_q[cnt_q[3:2]];
                o_mma_b      = b_q[cnt_q[1:0]];
                o_mma_c      = acc_mode_q ? c_q[cnt_q] : '0;
                c_d[cnt_q]   = i_mma_c;
                cnt_d        = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_DRAIN;
                    cnt_d   = 4'd0;
                end
            end
            S_DRAIN: begin
                o_busy      = 1'b1;
                o_res_valid = 1'b1;
                o_res_data  = c_q[cnt_q];
                o_res_row   = cnt_q[3:2];
                o_res_col   = cnt_q[1:0];
                o_res_last  = (cnt_q == 4'd15);
                if (i_res_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_done = done_q;

    // Reset clears operand and result storage so a post-reset accumulate starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            acc_mode_q <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) c_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_mode_q <= acc_mode_d;
            done_q     <= done_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
        end
    end

endmodule

// File: tb/tb_tensor_core_mma_seq.sv
// Directed bench for tensor_core_mma_seq with a C_out = C_in + 1 datapath model.
module tb_tensor_core_mma_seq;

    localparam int DW = 16;
    localparam int AW = 91;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_load_valid, o_load_ready, i_load_sel;
    logic [1:0]      i_load_idx;
    logic [4*DW-1:0] i_load_data;
    logic            i_start, i_acc, o_busy, o_done;
    logic [4*DW-1:0] o_mma_a, o_mma_b;
    logic [AW-1:0]   o_mma_c, i_mma_c;
    logic            o_res_valid, i_res_ready, o_res_last;
    logic [AW-1:0]   o_res_data;
    logic [1:0]      o_res_row, o_res_col;

    tensor_core_mma_seq #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_load_sel(i_load_sel), .i_load_idx(i_load_idx), .i_load_data(i_load_data),
        .i_start(i_start), .i_acc(i_acc), .o_busy(o_busy), .o_done(o_done),
        .o_mma_a(o_mma_a), .o_mma_b(o_mma_b), .o_mma_c(o_mma_c), .i_mma_c(i_mma_c),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
        .o_res_row(o_res_row), .o_res_col(o_res_col), .o_res_last(o_res_last)
    );

    assign i_mma_c = o_mma_c + 91'd1;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4*DW-1:0] a_m [4];
    logic [4*DW-1:0] b_m [4];
    logic [AW-1:0]   c_m [16];

    typedef struct {
        logic        acc;
        int          rmode;
        bit          poke;
        logic [AW-1:0] exp_v;
    } vec_t;

    vec_t vecs [5];

    function automatic void chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " load_ready"}, AW'(o_load_ready), 1);
        chk({tag, " busy"},       AW'(o_busy), 0);
        chk({tag, " done"},       AW'(o_done), 0);
        chk({tag, " mma_a"},      AW'(o_mma_a), 0);
        chk({tag, " mma_b"},      AW'(o_mma_b), 0);
        chk({tag, " mma_c"},      o_mma_c, 0);
        chk({tag, " res_valid"},  AW'(o_res_valid), 0);
        chk({tag, " res_data"},   o_res_data, 0);
        chk({tag, " res_rowcol"}, AW'({o_res_row, o_res_col, o_res_last}), 0);
    endtask

    task automatic load_beat(input logic sel, input logic [1:0] idx, input logic [4*DW-1:0] d);
        i_load_valid = 1'b1; i_load_sel = sel; i_load_idx = idx; i_load_data = d;
        chk("load_ready_idle", AW'(o_load_ready), 1);
        @(posedge clk); @(negedge clk);
        i_load_valid = 1'b0;
        if (sel) b_m[idx] = d; else a_m[idx] = d;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 4; i++) begin a_m[i] = '0; b_m[i] = '0; end
        for (int i = 0; i < 16; i++) c_m[i] = '0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 4; i++) load_beat(1'b0, 2'(i), {4{16'h3C00}});
        for (int i = 0; i < 4; i++) load_beat(1'b1, 2'(i), {4{16'h4000}});
    endtask

    // Starts one operation from a negedge and follows it until o_done, checking every cycle.
    task automatic run_mma(input logic acc, input int rmode, input bit poke, input logic [AW-1:0] exp_v);
        int cyc, got, ci, dci, ndone;
        bit xfer, stalled;
        logic [AW-1:0] held;
        logic [3:0] pat;
        pat = 4'b1001;
        got = 0; ci = 0; dci = 0; xfer = 0; stalled = 0; held = '0;
        i_start = 1'b1; i_acc = acc;
        @(posedge clk); cyc = 1;
        @(negedge clk);
        while (!o_done && cyc < 300) begin
            i_start = 1'b0; i_load_valid = 1'b0; i_acc = 1'b0;
            if (o_busy && !o_res_valid && ci < 16) begin
                chk("mma_a", AW'(o_mma_a), AW'(a_m[ci/4]));
                chk("mma_b", AW'(o_mma_b), AW'(b_m[ci%4]));
                chk("mma_c", o_mma_c, acc ? c_m[ci] : '0);
                c_m[ci] = (acc ? c_m[ci] : '0) + 91'd1;
                if (poke && ci == 2) begin
                    i_start = 1'b1; i_acc = 1'b1;
                    i_load_valid = 1'b1; i_load_sel = 1'b0; i_load_idx = 2'd1;
                    i_load_data = 64'hDEAD_BEEF_0BAD_F00D;
                    chk("load_ready_busy", AW'(o_load_ready), 0);
                end
                ci++;
            end else if (o_res_valid) begin
                chk("res_data", o_res_data, exp_v);
                chk("res_row", AW'(o_res_row), AW'(got / 4));
                chk("res_col", AW'(o_res_col), AW'(got % 4));
                chk("res_last", AW'(o_res_last), AW'(got == 15));
                chk("mma_a_drain", AW'(o_mma_a), 0);
                if (stalled) chk("stall_hold", o_res_data, held);
                i_res_ready = (rmode == 1) ? pat[3 - (dci % 4)] : 1'b1;
                if (poke && dci == 3) i_start = 1'b1;
                xfer = i_res_ready;
                stalled = !i_res_ready;
                held = o_res_data;
                dci++;
            end
            @(posedge clk); cyc++;
            if (xfer) got++;
            xfer = 0;
            @(negedge clk);
        end
        i_start = 1'b0; i_load_valid = 1'b0; i_res_ready = 1'b1;
        chk("done_seen", AW'(o_done), 1);
        chk("xfer_count", AW'(got), 16);
        if (rmode == 0) chk("latency", AW'(cyc), 33);
        chk("busy_at_done", AW'(o_busy), 0);
        chk("load_ready_at_done", AW'(o_load_ready), 1);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (o_done || o_busy) ndone++;
        end
        chk("single_done", AW'(ndone), 0);
    endtask

    initial begin
        rst_n = 1'b0; i_load_valid = 1'b0; i_load_sel = 1'b0; i_load_idx = 2'd0;
        i_load_data = '0; i_start = 1'b0; i_acc = 1'b0; i_res_ready = 1'b1;
        clear_models();

        vecs[0] = '{acc: 1'b0, rmode: 0, poke: 1'b0, exp_v: 91'd1};
        vecs[1] = '{acc: 1'b1, rmode: 0, poke: 1'b0, exp_v: 91'd2};
        vecs[2] = '{acc: 1'b0, rmode: 0, poke: 1'b0, exp_v: 91'd1};
        vecs[3] = '{acc: 1'b1, rmode: 1, poke: 1'b0, exp_v: 91'd2};
        vecs[4] = '{acc: 1'b0, rmode: 0, poke: 1'b1, exp_v: 91'd1};

        #12;
        chk_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        load_all();
        for (int v = 0; v < 5; v++) run_mma(vecs[v].acc, vecs[v].rmode, vecs[v].poke, vecs[v].exp_v);

        // Load and start taken on the same edge; rows 2 must show the new A[2].
        i_load_valid = 1'b1; i_load_sel = 1'b0; i_load_idx = 2'd2; i_load_data = {4{16'h4400}};
        a_m[2] = {4{16'h4400}};
        run_mma(1'b0, 0, 1'b0, 91'd1);

        // Reset at cnt = 7 of COMPUTE.
        i_start = 1'b1; i_acc = 1'b1;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0; i_acc = 1'b0;
        repeat (7) begin @(posedge clk); @(negedge clk); end
        chk("pre_reset_mma_a", AW'(o_mma_a), AW'(a_m[1]));
        chk("pre_reset_mma_c", o_mma_c, c_m[7]);
        rst_n = 1'b0; #1;
        chk_reset_outputs("rst_compute");
        @(negedge clk); rst_n = 1'b1;
        clear_models();

        // Reset in the middle of DRAIN.
        load_all();
        i_start = 1'b1; i_acc = 1'b0;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        repeat (20) begin @(posedge clk); @(negedge clk); end
        chk("pre_reset_drain_valid", AW'(o_res_valid), 1);
        rst_n = 1'b0; #1;
        chk_reset_outputs("rst_drain");
        @(negedge clk); rst_n = 1'b1;
        clear_models();
        begin
            int nd;
            nd = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); @(negedge clk);
                if (o_done || o_busy) nd++;
            end
            chk("no_done_after_reset", AW'(nd), 0);
        end

        // C was cleared by reset, so accumulate starts from zero.
        load_all();
        run_mma(1'b1, 0, 1'b0, 91'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
